// File: rtl/cmd_decoder_if.sv
// Command/response word channels between the serial link and the frontend
// command decoder. Each direction is a valid/ready handshake; a word moves in
// any cycle where both valid and ready are high.
interface cmd_decoder_if;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] rsp_data;
   logic        rsp_valid;
   logic        rsp_ready;

   // Serial side: supplies commands and consumes responses.
   modport master (
      output cmd_data, cmd_valid, rsp_ready,
      input  cmd_ready, rsp_data, rsp_valid
   );

   // Decoder side: consumes commands and supplies responses.
   modport slave (
      input  cmd_data, cmd_valid, rsp_ready,
      output cmd_ready, rsp_data, rsp_valid
   );
endinterface

// File: rtl/cmd_decoder.sv
// Frontend command decoder. Accepts one 32-bit command at a time, checks the
// header and target id, then either pulses a soft reset, writes a config bit,
// or returns a 16-bit slice of the period counter or a singles counter.
// 32-bit sources are read in two halves through a shadow register so that
// the two halves belong to the same sample.
module cmd_decoder #(
   parameter int NBLOCKS    = 4,
   parameter int RST_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            module_id,
   cmd_decoder_if.slave          bus,
   input  logic [31:0]           period,
   input  logic [32*NBLOCKS-1:0] singles,
   output logic                  soft_rst,
   output logic                  tt_stall_dis,
   output logic                  fe_dis,
   output logic [7:0]            err_count
);

   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [3:0] HEADER        = 4'hF;
   localparam logic [3:0] OP_SRST       = 4'h0;
   localparam logic [3:0] OP_RD_PERIOD  = 4'h9;
   localparam logic [3:0] OP_RD_SINGLES = 4'hA;
   localparam logic [3:0] OP_CFG        = 4'hB;
   localparam logic [3:0] CFG_KEY       = 4'h4;
   localparam logic [3:0] CFG_TT_STALL  = 4'h2;
   localparam logic [3:0] CFG_FE_DIS    = 4'h3;

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      RESP,
      SRST
   } state_t;

   state_t           state;
   logic [31:0]      cmd_q;
   logic [31:0]      shadow;
   logic [CNT_W-1:0] srst_cnt;
   logic [31:0]      blk_data;
   logic [31:0]      src_data;

   // Field views of the registered command word.
   logic [3:0] hdr;
   logic [3:0] tgt_id;
   logic [3:0] opcode;
   logic [3:0] cfg_key;
   logic [3:0] sel_idx;
   logic       cfg_en;
   logic       hi_half;

   assign hdr     = cmd_q[31:28];
   assign tgt_id  = cmd_q[27:24];
   assign opcode  = cmd_q[23:20];
   assign cfg_key = cmd_q[19:16];
   assign sel_idx = cmd_q[11:8];
   assign cfg_en  = cmd_q[4];
   assign hi_half = cmd_q[0];

   // Payload bits that no opcode interprets.
   logic unused_bits;
   assign unused_bits = ^{cmd_q[15:12], cmd_q[7:5], cmd_q[3:1]};

   // Select the addressed singles counter; out-of-range blocks read as zero.
   always_comb begin
      // NOTE: default assignment first so every path drives blk_data and no latch is inferred.
      blk_data = '0;
      for (int b = 0; b < NBLOCKS; b++) begin
         if (int'(sel_idx) == b) blk_data = singles[32*b +: 32];
      end
   end

   assign src_data = (opcode == OP_RD_PERIOD) ? period : blk_data;

   // Command FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
         state         <= IDLE;
         cmd_q         <= '0;
         shadow        <= '0;
         srst_cnt      <= '0;
         bus.cmd_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         soft_rst      <= 1'b0;
         tt_stall_dis  <= 1'b0;
         fe_dis        <= 1'b0;
         err_count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  cmd_q         <= bus.cmd_data;
                  bus.cmd_ready <= 1'b0;
                  state         <= DECODE;
               end
            end

            DECODE: begin
               // Default outcome is a silent drop back to IDLE.
               state         <= IDLE;
               bus.cmd_ready <= 1'b1;
               if (hdr != HEADER) begin
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               end else if (tgt_id == module_id) begin
                  case (opcode)
                     OP_SRST: begin
                        soft_rst      <= 1'b1;
                        srst_cnt      <= CNT_W'(RST_CYCLES - 1);
                        tt_stall_dis  <= 1'b0;
                        fe_dis        <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        state         <= SRST;
                     end
                     OP_CFG: begin
                        if (cfg_key == CFG_KEY && cfg_en) begin
                           if (sel_idx == CFG_TT_STALL) tt_stall_dis <= hi_half;
                           else if (sel_idx == CFG_FE_DIS) fe_dis <= hi_half;
                        end
                     end
                     OP_RD_PERIOD, OP_RD_SINGLES: begin
                        // Low-half read samples the source; high-half read replays the sample.
                        if (!hi_half) begin
                           shadow       <= src_data;
                           bus.rsp_data <= {HEADER, module_id, opcode, 4'h0, src_data[15:0]};
                        end else begin
                           bus.rsp_data <= {HEADER, module_id, opcode, 4'h0, shadow[31:16]};
                        end
                        bus.rsp_valid <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        state         <= RESP;
                     end
                     default: begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                     end
                  endcase
               end
            end

            RESP: begin
               if (bus.rsp_valid && bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end
            end

            SRST: begin
               if (srst_cnt == '0) begin
                  soft_rst      <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state         <= IDLE;
               end else begin
                  srst_cnt <= srst_cnt - 1'b1;
               end
            end

            default: begin
               state         <= IDLE;
               bus.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: a table of single-command vectors plus
// hand-written sequences for soft-reset timing, response back-pressure,
// error saturation and reset in the middle of a transaction. Response words
// are predicted into a queue when a read is sent and compared when the
// decoder hands them over.
module tb_cmd_decoder;

   logic         clk;
   logic         rst;
   logic [3:0]   module_id;
   logic [31:0]  period;
   logic [127:0] singles;
   logic         soft_rst;
   logic         tt_stall_dis;
   logic         fe_dis;
   logic [7:0]   err_count;

   cmd_decoder_if bus ();

   cmd_decoder #(
      .NBLOCKS    (4),
      .RST_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .module_id    (module_id),
      .bus          (bus),
      .period       (period),
      .singles      (singles),
      .soft_rst     (soft_rst),
      .tt_stall_dis (tt_stall_dis),
      .fe_dis       (fe_dis),
      .err_count    (err_count)
   );

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] period;
      logic        has_rsp;
      logic [31:0] rsp;
      logic        tt;
      logic        fe;
      logic [7:0]  err;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   int          n_vec;
   int          n_err;

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare every response handed over against the oldest prediction.
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", bus.rsp_data, 32'hxxxx_xxxx);
         end else begin
            check("rsp_data", bus.rsp_data, exp_q.pop_front());
         end
      end
   end

   task automatic add(input logic [31:0] cmd, input logic [31:0] per, input logic has,
                      input logic [31:0] rsp, input logic tt, input logic fe, input logic [7:0] err);
      vec_t v;
      v.cmd = cmd; v.period = per; v.has_rsp = has; v.rsp = rsp;
      v.tt = tt; v.fe = fe; v.err = err;
      vecs.push_back(v);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_cmd(input logic [31:0] w);
      int t;
      t = 0;
      while (bus.cmd_ready !== 1'b1 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check("cmd_ready_timeout", {31'b0, bus.cmd_ready}, 32'd1);
      bus.cmd_data  = w;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int t;
      t = 0;
      while (bus.rsp_valid !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20) check("rsp_valid_timeout", {31'b0, bus.rsp_valid}, 32'd1);
   endtask

   task automatic handshake();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic idle_no_rsp(input string name);
      logic saw;
      saw = 1'b0;
      repeat (3) begin
         saw = saw | (bus.rsp_valid === 1'b1);
         @(posedge clk); #1;
      end
      check(name, {31'b0, saw}, 32'd0);
   endtask

   initial begin
      int hi_cnt;
      int first_hi;
      int rdy_bad;

      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      module_id = 4'h0;
      period = 32'h0;
      singles = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_00AB, 32'h1111_2222};
      bus.cmd_data = '0;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'h0);
      check("rst_soft_rst", {31'b0, soft_rst}, 32'd0);
      check("rst_tt", {31'b0, tt_stall_dis}, 32'd0);
      check("rst_fe", {31'b0, fe_dis}, 32'd0);
      check("rst_err", {24'b0, err_count}, 32'd0);

      //   cmd            period         rsp?  rsp word       tt    fe    err
      add(32'hF0B4_0211, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 8'd0);
      add(32'hF0B4_0210, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 8'd0);
      add(32'hF0B4_0311, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd0);
      add(32'hF0B4_0201, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd0);
      add(32'hF0B5_0211, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd0);
      add(32'hF0B4_0511, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd0);
      add(32'hF090_0000, 32'h1234_5678, 1'b1, 32'hF090_5678, 1'b0, 1'b1, 8'd0);
      add(32'hF090_0001, 32'h0,         1'b1, 32'hF090_1234, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0100, 32'h0,         1'b1, 32'hF0A0_00AB, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0200, 32'h0,         1'b1, 32'hF0A0_BEEF, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0201, 32'h0,         1'b1, 32'hF0A0_DEAD, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0700, 32'h0,         1'b1, 32'hF0A0_0000, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0701, 32'h0,         1'b1, 32'hF0A0_0000, 1'b0, 1'b1, 8'd0);
      add(32'hF0A0_0300, 32'h0,         1'b1, 32'hF0A0_F00D, 1'b0, 1'b1, 8'd0);
      add(32'hF090_0001, 32'h7777_8888, 1'b1, 32'hF090_CAFE, 1'b0, 1'b1, 8'd0);
      add(32'hE000_0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd1);
      add(32'hF0C0_0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd2);
      add(32'hF100_0000, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 8'd2);
      add(32'hF0B4_0310, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 8'd2);
      add(32'hF0B4_0211, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 8'd2);

      foreach (vecs[i]) begin
         period = vecs[i].period;
         send_cmd(vecs[i].cmd);
         if (vecs[i].has_rsp) begin
            exp_q.push_back(vecs[i].rsp);
            wait_rsp();
            handshake();
            check($sformatf("vec%0d_drained", i), exp_q.size(), 32'd0);
         end else begin
            idle_no_rsp($sformatf("vec%0d_no_rsp", i));
         end
         check($sformatf("vec%0d_tt", i), {31'b0, tt_stall_dis}, {31'b0, vecs[i].tt});
         check($sformatf("vec%0d_fe", i), {31'b0, fe_dis}, {31'b0, vecs[i].fe});
         check($sformatf("vec%0d_err", i), {24'b0, err_count}, {24'b0, vecs[i].err});
         check($sformatf("vec%0d_ready", i), {31'b0, bus.cmd_ready}, 32'd1);
      end

      // Response latency and back-pressure: data held stable for 10 stalled cycles.
      send_cmd(32'hF0A0_0100);
      exp_q.push_back(32'hF0A0_00AB);
      check("lat_n1_valid", {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_n2_valid", {31'b0, bus.rsp_valid}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("stall%0d_valid", k), {31'b0, bus.rsp_valid}, 32'd1);
         check($sformatf("stall%0d_data", k), bus.rsp_data, 32'hF0A0_00AB);
         check($sformatf("stall%0d_ready", k), {31'b0, bus.cmd_ready}, 32'd0);
         @(posedge clk); #1;
      end
      handshake();
      check("post_xfer_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("post_xfer_ready", {31'b0, bus.cmd_ready}, 32'd1);

      // Soft-reset pulse: 16 cycles starting two cycles after accept.
      send_cmd(32'hF000_0000);
      check("srst_not_early", {31'b0, soft_rst}, 32'd0);
      hi_cnt = 0; first_hi = 0; rdy_bad = 0;
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         if (soft_rst === 1'b1) begin
            hi_cnt++;
            if (first_hi == 0) first_hi = k;
         end
         if (k == 1) check("srst_tt_cleared", {31'b0, tt_stall_dis}, 32'd0);
         if (k <= 16 && bus.cmd_ready !== 1'b0) rdy_bad++;
      end
      check("srst_first_cycle", first_hi, 32'd1);
      check("srst_length", hi_cnt, 32'd16);
      check("srst_ready_low", rdy_bad, 32'd0);
      check("srst_ready_after", {31'b0, bus.cmd_ready}, 32'd1);
      check("srst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

      // Error counter saturation, then an id mismatch leaves it alone.
      for (int k = 0; k < 300; k++) send_cmd(32'hE000_0000);
      @(posedge clk); #1;
      check("err_saturate", {24'b0, err_count}, 32'd255);
      send_cmd(32'hF100_0000);
      idle_no_rsp("id_mismatch_no_rsp");
      check("err_id_mismatch", {24'b0, err_count}, 32'd255);

      // Reset in the middle of the soft-reset pulse.
      send_cmd(32'hF000_0000);
      repeat (3) begin @(posedge clk); #1; end
      check("mid_srst_active", {31'b0, soft_rst}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_srst_soft_rst", {31'b0, soft_rst}, 32'd0);
      check("rst_srst_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("rst_srst_err", {24'b0, err_count}, 32'd0);

      // Reset while a response is pending; shadow must clear too.
      send_cmd(32'hF0B4_0311);
      idle_no_rsp("fe_set_no_rsp");
      check("fe_set", {31'b0, fe_dis}, 32'd1);
      period = 32'hABCD_1111;
      send_cmd(32'hF090_0000);
      wait_rsp();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_resp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check("rst_resp_data", bus.rsp_data, 32'h0);
      check("rst_resp_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("rst_resp_fe", {31'b0, fe_dis}, 32'd0);
      check("rst_resp_tt", {31'b0, tt_stall_dis}, 32'd0);
      period = 32'h5555_6666;
      send_cmd(32'hF090_0001);
      exp_q.push_back(32'hF090_0000);
      wait_rsp();
      handshake();

      repeat (2) @(posedge clk);
      #1;
      check("final_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
